// File: rtl/conv3x3_channel_accumulator.sv
// conv3x3_channel_accumulator
// 3x3 window MAC with per-column accumulation across input channels.
// Each pass handles one output row of one output channel. On the last
// channel the accumulated column results are rounded, saturated to Q8.8
// and streamed out on an AXI-Stream master, one beat per column.
module conv3x3_channel_accumulator #(
    parameter int DATA_WIDTH     = 16,
    parameter int ACC_WIDTH      = 44,
    parameter int MAX_IMAGE_SIZE = 64,
    parameter bit RELU_EN        = 1'b0
) (
    input  logic                         clk,
    input  logic                         Reset,
    input  logic                         Start_row,
    input  logic                         first_channel,
    input  logic                         last_channel,
    input  logic [6:0]                   IMAGE_SIZE,
    input  logic signed [DATA_WIDTH-1:0] in_window_00,
    input  logic signed [DATA_WIDTH-1:0] in_window_01,
    input  logic signed [DATA_WIDTH-1:0] in_window_02,
    input  logic signed [DATA_WIDTH-1:0] in_window_10,
    input  logic signed [DATA_WIDTH-1:0] in_window_11,
    input  logic signed [DATA_WIDTH-1:0] in_window_12,
    input  logic signed [DATA_WIDTH-1:0] in_window_20,
    input  logic signed [DATA_WIDTH-1:0] in_window_21,
    input  logic signed [DATA_WIDTH-1:0] in_window_22,
    input  logic signed [DATA_WIDTH-1:0] weight_00,
    input  logic signed [DATA_WIDTH-1:0] weight_01,
    input  logic signed [DATA_WIDTH-1:0] weight_02,
    input  logic signed [DATA_WIDTH-1:0] weight_10,
    input  logic signed [DATA_WIDTH-1:0] weight_11,
    input  logic signed [DATA_WIDTH-1:0] weight_12,
    input  logic signed [DATA_WIDTH-1:0] weight_20,
    input  logic signed [DATA_WIDTH-1:0] weight_21,
    input  logic signed [DATA_WIDTH-1:0] weight_22,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic                         Done_row,
    output logic                         busy
);
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int SUM_W  = PROD_W + 4;
    localparam int COL_W  = $clog2(MAX_IMAGE_SIZE);

    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = (ACC_WIDTH'(1) <<< (DATA_WIDTH - 1)) - ACC_WIDTH'(1);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = -OUT_MAX - ACC_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    // Round half-up from Q16.16 to Q8.8, optional ReLU, saturate to the output range
    function automatic logic signed [DATA_WIDTH-1:0] round_sat(input logic signed [ACC_WIDTH-1:0] a);
        logic signed [ACC_WIDTH-1:0] r;
        r = (a + ACC_WIDTH'(128)) >>> 8;
        if (RELU_EN && r[ACC_WIDTH-1]) r = '0;
        if (r > OUT_MAX) r = OUT_MAX;
        if (r < OUT_MIN) r = OUT_MIN;
        return r[DATA_WIDTH-1:0];
    endfunction

    logic signed [DATA_WIDTH-1:0] pix [9];
    logic signed [DATA_WIDTH-1:0] wgt [9];

    assign pix = '{in_window_00, in_window_01, in_window_02,
                   in_window_10, in_window_11, in_window_12,
                   in_window_20, in_window_21, in_window_22};
    assign wgt = '{weight_00, weight_01, weight_02,
                   weight_10, weight_11, weight_12,
                   weight_20, weight_21, weight_22};

    state_t                         state_q;
    logic [COL_W-1:0]               col_q;
    logic [6:0]                     last_col_q;
    logic                           first_q;
    logic                           last_q;
    logic                           vld_p1;
    logic                           vld_p2;
    logic                           tvalid_q;
    logic                           tlast_q;
    logic signed [DATA_WIDTH-1:0]   tdata_q;

    logic signed [PROD_W-1:0]       prod_p1 [9];
    logic [COL_W-1:0]               col_p1;
    logic signed [SUM_W-1:0]        sum_p2;
    logic [COL_W-1:0]               col_p2;
    logic signed [ACC_WIDTH-1:0]    acc_q [MAX_IMAGE_SIZE];

    logic                           adv;
    logic                           accept;
    logic                           drain_done;
    logic signed [SUM_W-1:0]        sum_d;
    logic signed [ACC_WIDTH-1:0]    acc_d;

    assign adv        = !(tvalid_q && !m_axis_tready);
    assign in_ready   = (state_q == RUN) && adv;
    assign accept     = in_valid && in_ready;
    assign drain_done = !vld_p1 && !vld_p2 && !tvalid_q;

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign Done_row      = (state_q == DRAIN) && drain_done;
    assign busy          = (state_q != IDLE);

    // Adder tree over the nine registered products
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < 9; i++) sum_d = sum_d + SUM_W'(prod_p1[i]);
    end

    // First channel overwrites the column, later channels add to it
    always_comb begin
        acc_d = first_q ? ACC_WIDTH'(sum_p2) : acc_q[col_p2] + ACC_WIDTH'(sum_p2);
    end

    // Row sequencing FSM, pipeline valids and the output register
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            col_q      <= '0;
            last_col_q <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start_row) begin
                        state_q    <= RUN;
                        col_q      <= '0;
                        last_col_q <= IMAGE_SIZE - 7'd1;
                        first_q    <= first_channel;
                        last_q     <= last_channel;
                    end
                end
                RUN: begin
                    if (accept) begin
                        col_q <= col_q + COL_W'(1);
                        if (7'(col_q) == last_col_q) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_done) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (adv) begin
                vld_p1   <= accept;
                vld_p2   <= vld_p1;
                tvalid_q <= vld_p2 && last_q;
                if (vld_p2 && last_q) begin
                    tdata_q <= round_sat(acc_d);
                    tlast_q <= (7'(col_p2) == last_col_q);
                end
            end
        end
    end

    // Datapath: products (S1), window sum (S2), column accumulator write (S3)
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int i = 0; i < 9; i++) prod_p1[i] <= PROD_W'(pix[i]) * PROD_W'(wgt[i]);
            col_p1 <= col_q;
            sum_p2 <= sum_d;
            col_p2 <= col_p1;
            if (vld_p2) acc_q[col_p2] <= acc_d;
        end
    end

endmodule
